// File: rtl/conv_controller.sv
// conv_controller
//   Sequencer for one convolver datapath. It strobes the weight-register write, admits one
//   IMAGE_SIZE x IMAGE_SIZE pixel frame in raster order over a valid/ready handshake (gating
//   the datapath shift chain), flags the cycles on which add_result carries a valid
//   convolution output together with its output row/column, and reports busy/done.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low reset
//   start      begin a frame (sampled only in IDLE)
//   abort      cancel the current frame (wins over start)
//   in_pixel   raster pixel from upstream
//   in_valid   in_pixel valid
//   in_ready   controller accepts a pixel this cycle
//   dp_pixel   datapath pixel input (pass-through of in_pixel)
//   dp_en      datapath shift-chain advance enable
//   dp_write   datapath weight-register write strobe
//   out_valid  add_result valid this cycle
//   out_row    output row of the current result
//   out_col    output column of the current result
//   busy       high in every state except IDLE
//   done       one-cycle end-of-frame pulse
module conv_controller #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned KERNEL_SIZE  = 5,
   parameter int unsigned IMAGE_SIZE   = 28,
   parameter int unsigned PIPE_LATENCY = 0,
   localparam int unsigned OutW = ((IMAGE_SIZE - KERNEL_SIZE + 1) > 1) ?
                                  $clog2(IMAGE_SIZE - KERNEL_SIZE + 1) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] in_pixel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] dp_pixel,
   output logic                  dp_en,
   output logic                  dp_write,
   output logic                  out_valid,
   output logic [OutW-1:0]       out_row,
   output logic [OutW-1:0]       out_col,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CntW   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int unsigned Depth  = PIPE_LATENCY + 1;
   localparam int unsigned DrainW = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;

   localparam logic [CntW-1:0]   LastPix   = CntW'(IMAGE_SIZE - 1);
   localparam logic [CntW-1:0]   FirstWin  = CntW'(KERNEL_SIZE - 1);
   localparam logic [OutW-1:0]   LastOut   = OutW'(IMAGE_SIZE - KERNEL_SIZE);
   localparam logic [DrainW-1:0] LastDrain = DrainW'(PIPE_LATENCY);

   typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   row_q, row_d, col_q, col_d;
   logic [OutW-1:0]   orow_q, orow_d, ocol_q, ocol_d;
   logic [DrainW-1:0] drain_q, drain_d;
   logic [Depth-1:0]  vld_q, vld_d;
   logic              in_ready_q, in_ready_d;
   logic              dp_write_q, dp_write_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept, push;

   // in_ready_q is only ever high in STREAM, so accept needs no separate state qualifier.
   assign accept = in_valid & in_ready_q & ~abort;
   // Window is complete once both counters have reached K-1.
   assign push   = accept & (row_q >= FirstWin) & (col_q >= FirstWin);

   assign dp_pixel  = in_pixel;
   assign dp_en     = accept;
   assign in_ready  = in_ready_q;
   assign dp_write  = dp_write_q;
   assign out_valid = vld_q[Depth-1];
   assign out_row   = orow_q;
   assign out_col   = ocol_q;
   assign busy      = busy_q;
   assign done      = done_q;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      drain_d = drain_q;

      // Free-running valid delay line, matched to the datapath latency.
      vld_d    = vld_q << 1;
      vld_d[0] = push;

      // Output coordinates advance after each flagged result.
      if (vld_q[Depth-1]) begin
         if (ocol_q == LastOut) begin
            ocol_d = '0;
            orow_d = (orow_q == LastOut) ? '0 : orow_q + OutW'(1);
         end else begin
            ocol_d = ocol_q + OutW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoadW;
               row_d   = '0;
               col_d   = '0;
               orow_d  = '0;
               ocol_d  = '0;
               drain_d = '0;
            end
         end
         StLoadW: state_d = StStream;
         StStream: begin
            if (accept) begin
               if (col_q == LastPix) begin
                  col_d = '0;
                  if (row_q == LastPix) begin
                     row_d   = '0;
                     drain_d = '0;
                     state_d = StDrain;
                  end else begin
                     row_d = row_q + CntW'(1);
                  end
               end else begin
                  col_d = col_q + CntW'(1);
               end
            end
         end
         // The last push leaves the delay line after exactly Depth cycles.
         StDrain: begin
            if (drain_q == LastDrain) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + DrainW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d = StIdle;
         row_d   = '0;
         col_d   = '0;
         orow_d  = '0;
         ocol_d  = '0;
         drain_d = '0;
         vld_d   = '0;
      end

      in_ready_d = (state_d == StStream);
      dp_write_d = (state_d == StLoadW);
      busy_d     = (state_d != StIdle);
      done_d     = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         row_q      <= '0;
         col_q      <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         drain_q    <= '0;
         vld_q      <= '0;
         in_ready_q <= 1'b0;
         dp_write_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         orow_q     <= orow_d;
         ocol_q     <= ocol_d;
         drain_q    <= drain_d;
         vld_q      <= vld_d;
         in_ready_q <= in_ready_d;
         dp_write_q <= dp_write_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: three instances (N=6/K=3/PL=0, N=6/K=3/PL=2, N=28/K=5/PL=0)
// driven one at a time with randomized valid gaps, checked against a timeline model.
module tb_conv_controller;

   logic clk;
   logic reset;
   logic        start_s [3];
   logic        abort_s [3];
   logic        vld_s   [3];
   logic [15:0] pix_s   [3];
   logic        ir      [3];
   logic        dpen    [3];
   logic        dpw     [3];
   logic        ov      [3];
   logic        busy_s  [3];
   logic        done_s  [3];
   logic [15:0] dpp     [3];
   logic [4:0]  orow    [3];
   logic [4:0]  ocol    [3];
   logic [1:0]  orow0, ocol0, orow1, ocol1;
   logic [4:0]  orow2, ocol2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign orow[0] = {3'b000, orow0};
   assign ocol[0] = {3'b000, ocol0};
   assign orow[1] = {3'b000, orow1};
   assign ocol[1] = {3'b000, ocol1};
   assign orow[2] = orow2;
   assign ocol[2] = ocol2;

   conv_controller #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .IMAGE_SIZE(6), .PIPE_LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]), .in_pixel(pix_s[0]),
      .in_valid(vld_s[0]), .in_ready(ir[0]), .dp_pixel(dpp[0]), .dp_en(dpen[0]),
      .dp_write(dpw[0]), .out_valid(ov[0]), .out_row(orow0), .out_col(ocol0),
      .busy(busy_s[0]), .done(done_s[0]));

   conv_controller #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .IMAGE_SIZE(6), .PIPE_LATENCY(2)) u_dut1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]), .in_pixel(pix_s[1]),
      .in_valid(vld_s[1]), .in_ready(ir[1]), .dp_pixel(dpp[1]), .dp_en(dpen[1]),
      .dp_write(dpw[1]), .out_valid(ov[1]), .out_row(orow1), .out_col(ocol1),
      .busy(busy_s[1]), .done(done_s[1]));

   conv_controller #(.DATA_WIDTH(16), .KERNEL_SIZE(5), .IMAGE_SIZE(28), .PIPE_LATENCY(0)) u_dut2 (
      .clk(clk), .reset(reset), .start(start_s[2]), .abort(abort_s[2]), .in_pixel(pix_s[2]),
      .in_valid(vld_s[2]), .in_ready(ir[2]), .dp_pixel(dpp[2]), .dp_en(dpen[2]),
      .dp_write(dpw[2]), .out_valid(ov[2]), .out_row(orow2), .out_col(ocol2),
      .busy(busy_s[2]), .done(done_s[2]));

   function automatic int cfg_n(input int d);
      return (d == 2) ? 28 : 6;
   endfunction

   function automatic int cfg_k(input int d);
      return (d == 2) ? 5 : 3;
   endfunction

   function automatic int cfg_pl(input int d);
      return (d == 1) ? 2 : 0;
   endfunction

   // Runs one frame on instance d starting from IDLE. Timeline phases of the model:
   // 0 start cycle, 1 weight load, 2 streaming, 3 drain, 4 done, 5 quiet cycles after
   // abort/reset. A result is expected 1+PL cycles after each accept of a complete window.
   task automatic run_frame(input int d, input int gap_pct, input int abort_after,
                            input bit noise_start, input bit rst_drain);
      int n, k, pl, m;
      int cyc, acc, nout, act_ov, ph, dcnt, post;
      int due_q[$];
      bit exp_ov, vld, ab, fin;
      n = cfg_n(d); k = cfg_k(d); pl = cfg_pl(d); m = n - k + 1;
      cyc = 0; acc = 0; nout = 0; act_ov = 0; ph = 0; dcnt = 0; post = 0; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         exp_ov = (due_q.size() > 0) && (due_q[0] == cyc);
         if (ov[d] === 1'b1) act_ov++;
         total_cnt++;
         if (ir[d] !== (ph == 2))
            $display("FAIL in_ready d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, ir[d], ph == 2);
         else pass_cnt++;
         total_cnt++;
         if (dpw[d] !== (ph == 1))
            $display("FAIL dp_write d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, dpw[d], ph == 1);
         else pass_cnt++;
         total_cnt++;
         if (busy_s[d] !== (ph >= 1 && ph <= 4))
            $display("FAIL busy d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, busy_s[d],
                     ph >= 1 && ph <= 4);
         else pass_cnt++;
         total_cnt++;
         if (done_s[d] !== (ph == 4))
            $display("FAIL done d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, done_s[d], ph == 4);
         else pass_cnt++;
         total_cnt++;
         if (ov[d] !== exp_ov)
            $display("FAIL out_valid d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, ov[d], exp_ov);
         else pass_cnt++;
         if (exp_ov) begin
            total_cnt++;
            if (orow[d] !== 5'(nout / m) || ocol[d] !== 5'(nout % m))
               $display("FAIL out_coord d=%0d result=%0d got=(%0d,%0d) want=(%0d,%0d)", d, nout,
                        orow[d], ocol[d], nout / m, nout % m);
            else pass_cnt++;
            void'(due_q.pop_front());
            nout++;
         end
         if (ph == 5) begin
            total_cnt++;
            if (orow[d] !== 5'd0 || ocol[d] !== 5'd0)
               $display("FAIL coord_clear d=%0d got=(%0d,%0d) want=(0,0)", d, orow[d], ocol[d]);
            else pass_cnt++;
         end

         vld = (int'($urandom_range(99)) >= gap_pct);
         ab  = (ph == 2) && (abort_after >= 0) && (acc == abort_after);
         vld_s[d]   = vld;
         pix_s[d]   = 16'($urandom);
         abort_s[d] = ab;
         start_s[d] = (ph == 0) || (noise_start && ph == 2 && $urandom_range(3) == 0);
         if (ph == 5) reset = 1'b1;
         if (ph == 3 && rst_drain) reset = 1'b0;
         #1;
         total_cnt++;
         if (dpen[d] !== (ph == 2 && vld && !ab))
            $display("FAIL dp_en d=%0d ph=%0d cyc=%0d got=%b want=%b", d, ph, cyc, dpen[d],
                     ph == 2 && vld && !ab);
         else pass_cnt++;
         total_cnt++;
         if (dpp[d] !== pix_s[d])
            $display("FAIL dp_pixel d=%0d cyc=%0d got=%h want=%h", d, cyc, dpp[d], pix_s[d]);
         else pass_cnt++;

         case (ph)
            0: ph = 1;
            1: ph = 2;
            2: begin
               if (ab) begin
                  due_q.delete();
                  ph = 5;
               end else if (vld) begin
                  if ((acc / n) >= k - 1 && (acc % n) >= k - 1) due_q.push_back(cyc + 1 + pl);
                  acc++;
                  if (acc == n * n) ph = 3;
               end
            end
            3: begin
               if (rst_drain) begin
                  due_q.delete();
                  ph = 5;
               end else begin
                  dcnt++;
                  if (dcnt == pl + 1) ph = 4;
               end
            end
            4: fin = 1'b1;
            default: begin
               post++;
               if (post == 3) fin = 1'b1;
            end
         endcase
         cyc++;
      end
      vld_s[d]   = 1'b0;
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      if (abort_after < 0 && !rst_drain) begin
         total_cnt++;
         if (act_ov !== m * m)
            $display("FAIL result_count d=%0d got=%0d want=%0d", d, act_ov, m * m);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b1; abort_s[d] = 1'b0; vld_s[d] = 1'b1; pix_s[d] = 16'h1234;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         total_cnt++;
         if ({ir[d], dpw[d], ov[d], busy_s[d], done_s[d], dpen[d]} !== 6'b0)
            $display("FAIL reset_flags d=%0d got=%b want=000000", d,
                     {ir[d], dpw[d], ov[d], busy_s[d], done_s[d], dpen[d]});
         else pass_cnt++;
         total_cnt++;
         if (orow[d] !== 5'd0 || ocol[d] !== 5'd0)
            $display("FAIL reset_coord d=%0d got=(%0d,%0d) want=(0,0)", d, orow[d], ocol[d]);
         else pass_cnt++;
         start_s[d] = 1'b0; vld_s[d] = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      run_frame(0, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_random_gaps();
      run_frame(0, 50, -1, 1'b0, 1'b0);
   endtask

   task automatic test_pipe_latency();
      run_frame(1, 0, -1, 1'b0, 1'b0);
      run_frame(1, 40, -1, 1'b0, 1'b0);
   endtask

   task automatic test_default_size();
      run_frame(2, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      run_frame(0, 0, 20, 1'b0, 1'b0);
      run_frame(0, 30, -1, 1'b0, 1'b0);
   endtask

   task automatic test_start_mid_stream();
      run_frame(0, 20, -1, 1'b1, 1'b0);
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start_s[0] = 1'b0;
         abort_s[0] = 1'b0;
         total_cnt++;
         if ({busy_s[0], dpw[0], ir[0], done_s[0]} !== 4'b0)
            $display("FAIL start_abort_idle cyc=%0d got=%b want=0000", i,
                     {busy_s[0], dpw[0], ir[0], done_s[0]});
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_in_drain();
      run_frame(0, 0, -1, 1'b0, 1'b1);
      run_frame(0, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_frame(0, 0, -1, 1'b0, 1'b0);
      run_frame(0, 50, -1, 1'b0, 1'b0);
      run_frame(1, 0, -1, 1'b0, 1'b0);
      run_frame(1, 0, -1, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0; abort_s[d] = 1'b0; vld_s[d] = 1'b0; pix_s[d] = '0;
      end
      test_reset();
      test_basic_frame();
      test_random_gaps();
      test_pipe_latency();
      test_default_size();
      test_abort();
      test_start_mid_stream();
      test_start_abort_idle();
      test_reset_in_drain();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
